axis_packet_summarizer: RTL and testbench



---
 rtl/axis_packet_summarizer_pkg.sv | 15 +
 rtl/axis_packet_summarizer_packet_accumulator.sv | 43 ++++
 rtl/axis_packet_summarizer.sv | 104 ++++++++++
 tb/tb_axis_packet_summarizer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_summarizer_pkg.sv
// Shared types and constants for the AXI-Stream packet summarizer.
package axis_packet_summarizer_pkg;

  typedef enum logic [1:0] {
    ACCUM     = 2'd0,
    SEND_SUM  = 2'd1,
    SEND_INFO = 2'd2
  } state_t;

  // Flag positions in the info word, counted down from the MSB
  localparam int SEQ_ERR_BIT  = 0;
  localparam int STRB_ERR_BIT = 1;
  localparam int LEN_ERR_BIT  = 2;

endpackage

// File: rtl/axis_packet_summarizer_packet_accumulator.sv
// Per-packet sum, beat count, sequence and strobe checks; cleared once the summary is sent.
module packet_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_BEATS  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   tdata,
  input  logic [DATA_WIDTH/8-1:0] tstrb,
  output logic [DATA_WIDTH-1:0]   sum,
  output logic [CNT_WIDTH-1:0]    count,
  output logic                    seq_err,
  output logic                    strb_err,
  output logic                    len_err
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BEATS);

  logic [DATA_WIDTH-1:0] expected;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum      <= '0;
      count    <= '0;
      expected <= '0;
      seq_err  <= 1'b0;
      strb_err <= 1'b0;
    end else if (en) begin
      sum      <= sum + tdata;
      if (count != '1) count <= count + CNT_WIDTH'(1);
      // Wrap of expected is intentional: all-ones followed by zero is a legal sequence
      expected <= tdata + DATA_WIDTH'(1);
      if (count != '0 && tdata != expected) seq_err <= 1'b1;
      if (tstrb != '1) strb_err <= 1'b1;
    end
  end

  assign len_err = count > MAX_CNT;

endmodule

// File: rtl/axis_packet_summarizer.sv
// End-of-chain checker: folds each input packet into a 2-beat summary (sum, flags+count).
module axis_packet_summarizer
  import axis_packet_summarizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_BEATS  = 64
) (
  input  logic                    s04_axis_aclk,
  input  logic                    s04_axis_areset,
  input  logic [DATA_WIDTH-1:0]   s04_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s04_axis_tstrb,
  input  logic                    s04_axis_tvalid,
  input  logic                    s04_axis_tlast,
  output logic                    s04_axis_tready,
  output logic [DATA_WIDTH-1:0]   m04_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m04_axis_tstrb,
  output logic                    m04_axis_tvalid,
  output logic                    m04_axis_tlast,
  input  logic                    m04_axis_tready,
  output logic                    pkt_done,
  output logic [CNT_WIDTH-1:0]    err_pkt_count
);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]  count;
  logic                  seq_err, strb_err, len_err;
  logic                  s_hs, info_done;
  logic [DATA_WIDTH-1:0] info;

  assign s04_axis_tready = (state == ACCUM) && !s04_axis_areset;
  assign s_hs            = s04_axis_tvalid && s04_axis_tready;
  assign info_done       = (state == SEND_INFO) && m04_axis_tready;

  packet_accumulator #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .MAX_BEATS (MAX_BEATS)
  ) u_acc (
    .clk     (s04_axis_aclk),
    .rst     (s04_axis_areset),
    .clr     (info_done),
    .en      (s_hs),
    .tdata   (s04_axis_tdata),
    .tstrb   (s04_axis_tstrb),
    .sum     (sum),
    .count   (count),
    .seq_err (seq_err),
    .strb_err(strb_err),
    .len_err (len_err)
  );

  always_comb begin
    info                              = '0;
    info[CNT_WIDTH-1:0]               = count;
    info[DATA_WIDTH-1-SEQ_ERR_BIT]    = seq_err;
    info[DATA_WIDTH-1-STRB_ERR_BIT]   = strb_err;
    info[DATA_WIDTH-1-LEN_ERR_BIT]    = len_err;
  end

  always_ff @(posedge s04_axis_aclk) begin
    if (s04_axis_areset) state <= ACCUM;
    else                 state <= state_nxt;
  end

  // Output beats come straight from registered state, so they hold while stalled
  always_comb begin
    state_nxt       = state;
    m04_axis_tvalid = 1'b0;
    m04_axis_tlast  = 1'b0;
    m04_axis_tdata  = '0;
    case (state)
      ACCUM: if (s_hs && s04_axis_tlast) state_nxt = SEND_SUM;
      SEND_SUM: begin
        m04_axis_tvalid = 1'b1;
        m04_axis_tdata  = sum;
        if (m04_axis_tready) state_nxt = SEND_INFO;
      end
      SEND_INFO: begin
        m04_axis_tvalid = 1'b1;
        m04_axis_tlast  = 1'b1;
        m04_axis_tdata  = info;
        if (m04_axis_tready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign m04_axis_tstrb = {(DATA_WIDTH/8){m04_axis_tvalid}};

  always_ff @(posedge s04_axis_aclk) begin
    if (s04_axis_areset) begin
      pkt_done      <= 1'b0;
      err_pkt_count <= '0;
    end else begin
      pkt_done <= info_done;
      if (info_done && (seq_err || strb_err || len_err) && err_pkt_count != '1)
        err_pkt_count <= err_pkt_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_packet_summarizer.sv
// Directed plus randomized packets scored against a queue-based reference model.
module tb_axis_packet_summarizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid, m_tlast, m_tready;
  logic        pkt_done;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_errs = 0;

  logic [31:0] pd[$];
  logic [3:0]  ps[$];

  always #5 clk = ~clk;

  axis_packet_summarizer #(.DATA_WIDTH(32), .CNT_WIDTH(16), .MAX_BEATS(64)) dut (
    .s04_axis_aclk  (clk),
    .s04_axis_areset(rst),
    .s04_axis_tdata (s_tdata),
    .s04_axis_tstrb (s_tstrb),
    .s04_axis_tvalid(s_tvalid),
    .s04_axis_tlast (s_tlast),
    .s04_axis_tready(s_tready),
    .m04_axis_tdata (m_tdata),
    .m04_axis_tstrb (m_tstrb),
    .m04_axis_tvalid(m_tvalid),
    .m04_axis_tlast (m_tlast),
    .m04_axis_tready(m_tready),
    .pkt_done       (pkt_done),
    .err_pkt_count  (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic full_strb();
    ps = {};
    foreach (pd[i]) ps.push_back(4'hF);
  endtask

  // Reference: sum mod 2^32, sequence/strobe/length flags straight from the packet contents
  function automatic logic [31:0] model_sum();
    logic [31:0] s = 32'd0;
    foreach (pd[i]) s += pd[i];
    return s;
  endfunction

  function automatic logic [31:0] model_info();
    bit sq = 0, sb = 0;
    int n = pd.size();
    foreach (pd[i]) begin
      if (i > 0 && pd[i] != pd[i-1] + 32'd1) sq = 1;
      if (ps[i] != 4'hF) sb = 1;
    end
    return {sq, sb, (n > 64), 13'd0, 16'((n > 65535) ? 65535 : n)};
  endfunction

  task automatic send(input bit gaps);
    for (int i = 0; i < pd.size(); i++) begin
      bit done = 0;
      int budget = 0;
      while (!done) begin
        if (gaps && $urandom_range(3) == 0) begin
          s_tvalid = 1'b0; s_tdata = $urandom; s_tlast = 1'b0;
          tick();
        end else begin
          s_tvalid = 1'b1; s_tdata = pd[i]; s_tstrb = ps[i];
          s_tlast  = (i == pd.size() - 1);
          done = s_tready;
          tick();
        end
        budget++;
        if (budget > 50 && !done) begin
          chk("send_timeout", 32'(s_tready), 32'd1);
          done = 1;
        end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic recv(input int stall0, input bit rnd, input logic [31:0] e_sum, input logic [31:0] e_info);
    chk("latency_tvalid", 32'(m_tvalid), 32'd1);
    for (int b = 0; b < 2; b++) begin
      int st = (b == 0) ? stall0 : 0;
      bit hs = 0;
      int cyc = 0;
      while (!hs) begin
        m_tready = (st > 0) ? 1'b0 : (rnd ? ($urandom_range(3) != 0) : 1'b1);
        chk(b ? "info_word" : "sum_word", m_tdata, b ? e_info : e_sum);
        chk("m_tvalid", 32'(m_tvalid), 32'd1);
        chk("m_tlast", 32'(m_tlast), 32'(b));
        chk("m_tstrb", 32'(m_tstrb), 32'hF);
        chk("s_tready_busy", 32'(s_tready), 32'd0);
        chk("pkt_done_early", 32'(pkt_done), 32'd0);
        hs = m_tready;
        if (st > 0) st--;
        tick();
        cyc++;
        if (cyc > 200) hs = 1;
      end
    end
    m_tready = 1'b0;
    chk("pkt_done_pulse", 32'(pkt_done), 32'd1);
    if (e_info[31:29] != 3'b000 && exp_errs < 65535) exp_errs++;
    chk("err_pkt_count", 32'(err_cnt), exp_errs);
    tick();
    chk("pkt_done_clear", 32'(pkt_done), 32'd0);
    chk("s_tready_idle", 32'(s_tready), 32'd1);
    chk("m_tvalid_idle", 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; s_tdata = '0; s_tstrb = 4'hF; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    tick(); tick();
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_tready", 32'(s_tready), 32'd1);

    pd = {32'd0, 32'd1, 32'd2, 32'd3}; full_strb();
    send(0); recv(0, 0, 32'h0000_0006, 32'h0000_0004);

    pd = {32'd5, 32'd6, 32'd9}; full_strb();
    send(0); recv(0, 0, 32'h0000_0014, 32'h8000_0003);

    pd = {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000}; full_strb();
    send(0); recv(0, 0, 32'hFFFF_FFFD, 32'h0000_0003);

    pd = {};
    for (int i = 0; i < 65; i++) pd.push_back(32'(i));
    full_strb();
    send(0); recv(5, 0, 32'h0000_0820, 32'h2000_0041);

    pd = {32'd1, 32'd2}; ps = {4'hF, 4'b0111};
    send(0); recv(0, 0, 32'h0000_0003, 32'h4000_0002);

    // Abort a packet after two beats; the follow-up packet must not inherit them
    s_tvalid = 1'b1; s_tstrb = 4'hF; s_tlast = 1'b0; s_tdata = 32'd10; tick();
    s_tdata = 32'd11; tick();
    s_tvalid = 1'b0; rst = 1'b1; tick();
    chk("abort_s_tready", 32'(s_tready), 32'd0);
    chk("abort_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("abort_err_clr", 32'(err_cnt), 32'd0);
    exp_errs = 0;
    rst = 1'b0; tick();
    pd = {32'd7}; full_strb();
    send(0); recv(0, 0, 32'h0000_0007, 32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      chk("single_summary", 32'(m_tvalid), 32'd0);
      tick();
    end

    // Reset while a summary is pending drops it
    pd = {32'd4, 32'd4}; full_strb();
    send(0);
    chk("pend_tvalid", 32'(m_tvalid), 32'd1);
    rst = 1'b1; tick();
    chk("midsum_tvalid", 32'(m_tvalid), 32'd0);
    rst = 1'b0; tick();
    chk("midsum_idle", 32'(m_tvalid), 32'd0);
    chk("midsum_tready", 32'(s_tready), 32'd1);

    for (int p = 0; p < 30; p++) begin
      int n = $urandom_range(70, 1);
      int mode = $urandom_range(2);
      logic [31:0] start = (mode == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      pd = {}; ps = {};
      for (int i = 0; i < n; i++) begin
        logic [31:0] d = start + 32'(i);
        if (mode == 2 && $urandom_range(9) == 0) d = $urandom;
        pd.push_back(d);
        ps.push_back(($urandom_range(15) == 0) ? 4'($urandom_range(14)) : 4'hF);
      end
      send(1);
      recv($urandom_range(3), 1, model_sum(), model_info());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
